// File: rtl/ac_zone_scheduler_pkg.sv
// Shared types and default parameters for the AC zone scheduler.
// The scheduler FSM states and the default temperature type live here.
package ac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, SWITCH} sched_state_t;

    localparam int NZONES_DEF      = 3;
    localparam int TBITS_DEF       = 3;
    localparam int STEP_CYCLES_DEF = 2;
    localparam int MAX_STEPS_DEF   = 2;
    localparam int DEAD_CYCLES_DEF = 1;

    typedef logic [TBITS_DEF-1:0] temp_t;

endpackage

// File: rtl/ac_zone_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending room after the
// last-served index, searching cyclically.
module rr_arbiter
    import ac_pkg::*;
#(
    parameter  int NZONES = NZONES_DEF,
    localparam int IW     = (NZONES > 1) ? $clog2(NZONES) : 1
) (
    input  logic [NZONES-1:0] pending,
    input  logic [IW-1:0]     last,
    output logic [NZONES-1:0] winner,
    output logic [IW-1:0]     winner_idx
);

    always_comb begin
        int   idx;
        logic found;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NZONES; k++) begin
            idx = (int'(last) + k) % NZONES;
            if (!found && pending[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ac_zone_scheduler.sv
// Shares one compressor among NZONES rooms: per-room setpoint buttons, a
// round-robin grant with forced rotation, and a dead-time gap between grants.
module ac_zone_scheduler
    import ac_pkg::*;
#(
    parameter int NZONES      = NZONES_DEF,
    parameter int TBITS       = TBITS_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int MAX_STEPS   = MAX_STEPS_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic                    clk_2,
    input  logic                    reset,
    input  logic [NZONES-1:0]       up_req,
    input  logic [NZONES-1:0]       down_req,
    output logic [NZONES*TBITS-1:0] desired_temp,
    output logic [NZONES*TBITS-1:0] real_temp,
    output logic [NZONES-1:0]       grant,
    output logic                    compressor_on,
    output logic                    heat_mode,
    output logic [NZONES-1:0]       settled,
    output logic                    busy
);

    localparam int IW = (NZONES > 1) ? $clog2(NZONES) : 1;
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int GW = $clog2(MAX_STEPS + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [TBITS-1:0] TMAX = {TBITS{1'b1}};

    sched_state_t     state_q, state_d;
    logic [IW-1:0]    g_q, g_d, ptr_q, ptr_d;
    logic [SW-1:0]    step_q, step_d;
    logic [GW-1:0]    gstep_q, gstep_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [TBITS-1:0] desired_q [NZONES];
    logic [TBITS-1:0] desired_d [NZONES];
    logic [TBITS-1:0] real_q    [NZONES];
    logic [TBITS-1:0] real_step;
    logic [NZONES-1:0] pending, win, g_onehot, settled_d;
    logic [IW-1:0]    win_idx;
    logic             any_pending, other_pending, heat, do_step;

    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            desired_d[i] = desired_q[i];
            if (up_req[i] && !down_req[i] && desired_q[i] != TMAX)
                desired_d[i] = desired_q[i] + TBITS'(1);
            else if (down_req[i] && !up_req[i] && desired_q[i] != '0)
                desired_d[i] = desired_q[i] - TBITS'(1);
            pending[i] = desired_q[i] != real_q[i];
        end
    end

    rr_arbiter #(.NZONES(NZONES)) u_arb (
        .pending    (pending),
        .last       (ptr_q),
        .winner     (win),
        .winner_idx (win_idx)
    );

    assign g_onehot      = NZONES'(1) << g_q;
    assign any_pending   = |pending;
    assign other_pending = |(pending & ~g_onehot);
    assign heat          = real_q[g_q] < desired_q[g_q];
    assign real_step     = heat ? real_q[g_q] + TBITS'(1) : real_q[g_q] - TBITS'(1);

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        step_d    = step_q;
        gstep_d   = gstep_q;
        dead_d    = dead_q;
        do_step   = 1'b0;
        settled_d = '0;
        unique case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d = RUN;
                    g_d     = win_idx;
                    ptr_d   = win_idx;
                    step_d  = '0;
                    gstep_d = '0;
                end
            end
            RUN: begin
                // Equality ends the grant even when a setpoint change caused it.
                if (!pending[g_q]) begin
                    state_d = any_pending ? SWITCH : IDLE;
                    dead_d  = '0;
                end else if (gstep_q == GW'(MAX_STEPS) && other_pending) begin
                    state_d = SWITCH;
                    dead_d  = '0;
                end else if (step_q == SW'(STEP_CYCLES - 1)) begin
                    do_step = 1'b1;
                    step_d  = '0;
                    if (gstep_q != GW'(MAX_STEPS))
                        gstep_d = gstep_q + GW'(1);
                    if (real_step == desired_d[g_q])
                        settled_d[g_q] = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            SWITCH: begin
                if (dead_q == DW'(DEAD_CYCLES - 1)) begin
                    if (any_pending) begin
                        state_d = RUN;
                        g_d     = win_idx;
                        ptr_d   = win_idx;
                        step_d  = '0;
                        gstep_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= IW'(NZONES - 1);
            step_q  <= '0;
            gstep_q <= '0;
            dead_q  <= '0;
            settled <= '0;
            for (int i = 0; i < NZONES; i++) begin
                desired_q[i] <= '0;
                real_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            gstep_q <= gstep_d;
            dead_q  <= dead_d;
            settled <= settled_d;
            for (int i = 0; i < NZONES; i++)
                desired_q[i] <= desired_d[i];
            if (do_step)
                real_q[g_q] <= real_step;
        end
    end

    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            desired_temp[i*TBITS +: TBITS] = desired_q[i];
            real_temp[i*TBITS +: TBITS]    = real_q[i];
        end
    end

    assign compressor_on = state_q == RUN;
    assign grant         = compressor_on ? g_onehot : '0;
    assign heat_mode     = compressor_on && heat;
    assign busy          = state_q != IDLE;

endmodule

// File: tb/tb_ac_zone_scheduler.sv
// Self-checking bench for ac_zone_scheduler: a setpoint vector table plus
// directed multi-cycle sequences for grant rotation, reversal and reset.
module tb_ac_zone_scheduler;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] up_req = '0;
    logic [2:0] down_req = '0;
    logic [8:0] desired_temp, real_temp;
    logic [2:0] grant, settled;
    logic       compressor_on, heat_mode, busy;

    int checks = 0;
    int errors = 0;

    ac_zone_scheduler dut (
        .clk_2         (clk_2),
        .reset         (reset),
        .up_req        (up_req),
        .down_req      (down_req),
        .desired_temp  (desired_temp),
        .real_temp     (real_temp),
        .grant         (grant),
        .compressor_on (compressor_on),
        .heat_mode     (heat_mode),
        .settled       (settled),
        .busy          (busy)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic [2:0] up;
        logic [2:0] dn;
        logic [8:0] exp_desired;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [8:0] pk(int d2, int d1, int d0);
        return 9'((d2 << 6) | (d1 << 3) | d0);
    endfunction

    function automatic logic [2:0] exp_grant_two(int e);
        if (e >= 2 && e <= 6)   return 3'b001;
        if (e >= 8 && e <= 12)  return 3'b010;
        if (e >= 14 && e <= 18) return 3'b001;
        if (e >= 20 && e <= 24) return 3'b010;
        return 3'b000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        up_req   = '0;
        down_req = '0;
        @(posedge clk_2);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int scount;
        int rmax;

        vecs[0]  = '{3'b100, 3'b001, pk(1, 0, 0)};
        vecs[1]  = '{3'b110, 3'b001, pk(2, 1, 0)};
        vecs[2]  = '{3'b100, 3'b001, pk(3, 1, 0)};
        vecs[3]  = '{3'b100, 3'b001, pk(4, 1, 0)};
        vecs[4]  = '{3'b100, 3'b001, pk(5, 1, 0)};
        vecs[5]  = '{3'b100, 3'b001, pk(6, 1, 0)};
        vecs[6]  = '{3'b100, 3'b001, pk(7, 1, 0)};
        vecs[7]  = '{3'b100, 3'b000, pk(7, 1, 0)};
        vecs[8]  = '{3'b111, 3'b111, pk(7, 1, 0)};
        vecs[9]  = '{3'b010, 3'b010, pk(7, 1, 0)};
        vecs[10] = '{3'b000, 3'b010, pk(7, 0, 0)};
        vecs[11] = '{3'b000, 3'b010, pk(7, 0, 0)};
        vecs[12] = '{3'b001, 3'b001, pk(7, 0, 0)};
        vecs[13] = '{3'b001, 3'b000, pk(7, 0, 1)};

        // single room heats 0 -> 3
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_comp", 32'(compressor_on), 0);
        chk("rst_desired", 32'(desired_temp), 0);
        chk("rst_real", 32'(real_temp), 0);
        up_req = 3'b001;
        tick();
        chk("t1_grant_e1", 32'(grant), 0);
        chk("t1_des0_e1", 32'(desired_temp[2:0]), 1);
        tick();
        chk("t1_grant_e2", 32'(grant), 1);
        chk("t1_heat_e2", 32'(heat_mode), 1);
        chk("t1_comp_e2", 32'(compressor_on), 1);
        tick();
        up_req = '0;
        chk("t1_des0_e3", 32'(desired_temp[2:0]), 3);
        scount = 0;
        for (int e = 4; e <= 9; e++) begin
            tick();
            if (settled[0]) scount++;
            if (e == 4) chk("t1_real0_e4", 32'(real_temp[2:0]), 1);
            if (e == 6) chk("t1_real0_e6", 32'(real_temp[2:0]), 2);
            if (e == 8) begin
                chk("t1_real0_e8", 32'(real_temp[2:0]), 3);
                chk("t1_settled_e8", 32'(settled), 1);
            end
            if (e == 9) begin
                chk("t1_grant_e9", 32'(grant), 0);
                chk("t1_busy_e9", 32'(busy), 0);
            end
        end
        chk("t1_settle_count", 32'(scount), 1);

        // two rooms share with forced rotation
        do_reset();
        up_req = 3'b011;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e == 4) up_req = '0;
            chk($sformatf("t2_grant_e%0d", e), 32'(grant), 32'(exp_grant_two(e)));
            if (e == 6)  chk("t2_real0_e6", 32'(real_temp[2:0]), 2);
            if (e == 12) chk("t2_real1_e12", 32'(real_temp[5:3]), 2);
            if (e == 18) chk("t2_real0_e18", 32'(real_temp[2:0]), 4);
            if (e == 24) chk("t2_real1_e24", 32'(real_temp[5:3]), 4);
        end
        chk("t2_busy_end", 32'(busy), 0);

        // setpoint saturation and conflicting buttons
        do_reset();
        for (int v = 0; v < 14; v++) begin
            up_req   = vecs[v].up;
            down_req = vecs[v].dn;
            tick();
            chk($sformatf("t3_desired_v%0d", v), 32'(desired_temp), 32'(vecs[v].exp_desired));
        end
        up_req   = '0;
        down_req = '0;

        // setpoint reversal mid-grant
        do_reset();
        up_req = 3'b101;
        tick();
        up_req = 3'b100;
        for (int e = 2; e <= 5; e++) begin
            tick();
            if (e == 2) chk("t4_grant_e2", 32'(grant), 1);
        end
        up_req = '0;
        scount = 0;
        rmax   = 0;
        for (int e = 6; e <= 13; e++) begin
            tick();
            if (settled[2]) scount++;
            if (int'(real_temp[8:6]) > rmax) rmax = int'(real_temp[8:6]);
            if (e == 6) begin
                down_req = 3'b100;
                chk("t4_grant_e6", 32'(grant), 4);
                chk("t4_des2_e6", 32'(desired_temp[8:6]), 5);
            end
            if (e == 8)  chk("t4_real2_e8", 32'(real_temp[8:6]), 1);
            if (e == 9)  chk("t4_heat_e9", 32'(heat_mode), 1);
            if (e == 10) begin
                down_req = '0;
                chk("t4_real2_e10", 32'(real_temp[8:6]), 2);
                chk("t4_des2_e10", 32'(desired_temp[8:6]), 1);
                chk("t4_heat_e10", 32'(heat_mode), 0);
            end
            if (e == 12) begin
                chk("t4_real2_e12", 32'(real_temp[8:6]), 1);
                chk("t4_settled_e12", 32'(settled), 4);
            end
            if (e == 13) chk("t4_busy_e13", 32'(busy), 0);
        end
        chk("t4_settle_count", 32'(scount), 1);
        chk("t4_real2_max", 32'(rmax), 2);

        // asynchronous reset in the middle of a grant
        do_reset();
        up_req = 3'b010;
        tick();
        up_req = '0;
        tick();
        tick();
        chk("t5_grant_before", 32'(grant), 2);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_grant_async", 32'(grant), 0);
        chk("t5_comp_async", 32'(compressor_on), 0);
        chk("t5_busy_async", 32'(busy), 0);
        chk("t5_heat_async", 32'(heat_mode), 0);
        chk("t5_desired_async", 32'(desired_temp), 0);
        chk("t5_real_async", 32'(real_temp), 0);
        #2;
        reset  = 1'b0;
        up_req = 3'b101;
        tick();
        up_req = '0;
        tick();
        chk("t5_grant_after", 32'(grant), 1);

        // setpoint lowered onto real before the step
        do_reset();
        up_req = 3'b001;
        tick();
        tick();
        tick();
        up_req = '0;
        tick();
        tick();
        tick();
        chk("t6_real0_e6", 32'(real_temp[2:0]), 2);
        down_req = 3'b001;
        tick();
        down_req = '0;
        chk("t6_des0_e7", 32'(desired_temp[2:0]), 2);
        chk("t6_grant_e7", 32'(grant), 1);
        tick();
        chk("t6_grant_e8", 32'(grant), 0);
        chk("t6_real0_e8", 32'(real_temp[2:0]), 2);
        chk("t6_settled_e8", 32'(settled), 0);
        tick();
        chk("t6_real0_e9", 32'(real_temp[2:0]), 2);
        chk("t6_settled_e9", 32'(settled), 0);
        chk("t6_busy_e9", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_zone_scheduler.md
Name: ac_zone_scheduler

Overview:
- Shares one air-conditioning compressor among NZONES rooms. Each room has its own desired and real temperature.
- Per-room up/down buttons adjust the desired setpoint. A round-robin scheduler grants the compressor to one room at a time and steps that room's real temperature toward its setpoint.
- Rotation is forced after MAX_STEPS steps, and a dead-time gap separates grants.
- Sits under top; switches drive the requests and LEDs show grant, mode and temperatures.

Parameters:
- NZONES, 3, number of rooms sharing the compressor.
- TBITS, 3, temperature width; range 0..2^TBITS-1.
- STEP_CYCLES, 2, clock cycles per one-unit temperature step.
- MAX_STEPS, 2, steps per grant before rotating, if another room is pending.
- DEAD_CYCLES, 1, compressor-off cycles between grants (>=1).

Ports:
- clk_2  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- up_req  in  NZONES  per-room raise-setpoint, level-sampled every cycle.
- down_req  in  NZONES  per-room lower-setpoint, level-sampled every cycle.
- desired_temp  out  NZONES*TBITS  packed setpoints; room i at [i*TBITS +: TBITS].
- real_temp  out  NZONES*TBITS  packed real temperatures, same packing.
- grant  out  NZONES  one-hot room owning the compressor; 0 when not in RUN.
- compressor_on  out  1  high only in RUN.
- heat_mode  out  1  in RUN, 1 if real<desired for the granted room, else 0; 0 outside RUN.
- settled  out  NZONES  one-cycle pulse when room i's real reaches its desired via a step.
- busy  out  1  high in RUN or SWITCH.

Behaviour:
- Reset (async, immediate):
  - all temperatures = 0; grant = 0; compressor_on = heat_mode = settled = busy = 0.
  - State = IDLE; round-robin last-served pointer = NZONES-1, so room 0 wins first.
  - Step counter = 0; grant-step counter = 0.
- Setpoint update, every cycle for each room i, independent of state:
  - up only: desired+1, saturating at 2^TBITS-1.
  - down only: desired-1, saturating at 0.
  - both or neither: unchanged.
- Pending(i) = desired[i] != real[i], evaluated on registered values.
- Arbitration: the first pending room after the last-served pointer, searched cyclically.
- States:
  - IDLE:
    - any pending: register grant = winner, set pointer = winner, clear counters, -> RUN.
    - otherwise stay.
  - RUN:
    - The step counter counts 0..STEP_CYCLES-1. At the wrap, real[g] moves one unit toward desired[g] and the grant-step counter increments.
    - Direction is recomputed each cycle from the current desired, so a setpoint reversal mid-grant changes direction at the next step.
    - If desired[g] == real[g] (either through a step or a setpoint change), leave RUN on the next edge with no further step:
      - any room pending -> SWITCH.
      - none pending -> IDLE.
    - Else if grant-step counter == MAX_STEPS and another room is pending -> SWITCH.
    - If no other room is pending, the grant-step counter is held at MAX_STEPS and the current room keeps running.
  - SWITCH:
    - grant = 0, compressor off, counter runs DEAD_CYCLES cycles.
    - Then re-arbitrate: any pending -> RUN with the new winner; else -> IDLE.
    - The same room may win again if it is the only one pending.
- Latency:
  - Request sampled at edge N; IDLE->RUN at edge N+1.
  - First step at edge N+1+STEP_CYCLES.
- settled[i] pulses in the cycle after the step that made real == desired. It does not pulse when equality comes from a setpoint change.
- Widths:
  - Step counter is $clog2(STEP_CYCLES+1) bits.
  - Grant-step counter is $clog2(MAX_STEPS+1) bits.
  - real never wraps because it only steps toward desired.

Decomposition:
- ac_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, SWITCH} sched_state_t;
  - default-parameter localparams.
  - temp_t, a TBITS-wide typedef.
- Sub-module rr_arbiter(NZONES):
  - inputs: pending vector and last-served pointer.
  - outputs: one-hot winner and winner index.
  - purely combinational.

Test Plan:
- Reset, then up_req[0]=1 for 3 cycles -> desired0=3; grant=001 and heat_mode=1 next cycle; real0 goes 1,2,3 at 2-cycle intervals; settled[0] pulses once; state returns to IDLE, grant=0.
- Rooms 0 and 1 both set to 4 in the same cycle -> room 0 steps to 2, SWITCH for 1 cycle, room 1 steps to 2, then room 0 to 4, then room 1 to 4; grant is never 011.
- Room 2 at desired 7: further up_req keeps it at 7. Room 0 at 0: down_req keeps it at 0. up and down high together -> unchanged.
- Room 2 desired 5, real reaches 2, then desired lowered to 1 -> heat_mode drops to 0; real goes 1 without reaching 3; settled[2] pulses when real=1.
- Assert reset mid-RUN, between clock edges -> all outputs 0 immediately, without a clock edge; after release, a new request starts arbitration at room 0.
- Granted room real=2, desired 3 is lowered to 2 before the step -> next edge leaves RUN; real stays 2; no settled pulse.
